// File: rtl/fft_stage_pingpong.sv
// Ping-pong frame buffer between two streaming FFT butterflies: one bank fills
// while the other, previously completed bank is read out with registered outputs.
module fft_stage_pingpong #(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_nd,
    input  logic [LOG_N-1:0] in_addr0,
    input  logic [LOG_N-1:0] in_addr1,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             in_ready,
    input  logic             rd_en,
    input  logic [LOG_N-1:0] rd_addr0,
    input  logic [LOG_N-1:0] rd_addr1,
    output logic             rd_avail,
    output logic             out_nd,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic             error
);
    localparam int CW = LOG_N - 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N / 2 - 1);

    logic [WIDTH-1:0] mem [0:2*N-1];
    logic             wbank, rbank;
    logic [CW-1:0]    wcnt, rcnt;
    logic [1:0]       full_cnt;
    logic             wr_acc, rd_acc, wr_done, rd_done;

    assign in_ready = (full_cnt != 2'd2);
    assign rd_avail = (full_cnt != 2'd0);
    assign wr_acc   = in_nd & in_ready;
    assign rd_acc   = rd_en & rd_avail;
    assign wr_done  = wr_acc && (wcnt == LAST_BEAT);
    assign rd_done  = rd_acc && (rcnt == LAST_BEAT);

    // Lane 1 is written last so it wins when both lanes hit the same address.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wbank, in_addr0}] <= in_data0;
            mem[{wbank, in_addr1}] <= in_data1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            full_cnt <= 2'd0;
            error    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wcnt <= wr_done ? '0 : wcnt + 1'b1;
                if (wr_done) wbank <= ~wbank;
            end
            if (rd_acc) begin
                rcnt <= rd_done ? '0 : rcnt + 1'b1;
                if (rd_done) rbank <= ~rbank;
            end
            // A frame completing and a frame releasing together cancel out.
            if (wr_done && !rd_done)
                full_cnt <= full_cnt + 2'd1;
            else if (rd_done && !wr_done)
                full_cnt <= full_cnt - 2'd1;
            if ((in_nd && !in_ready) || (rd_en && !rd_avail) ||
                (wr_acc && (in_addr0 == in_addr1)))
                error <= 1'b1;
        end
    end

    // Read stage: one-cycle registered lookup; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_nd    <= 1'b0;
            out_data0 <= '0;
            out_data1 <= '0;
        end else begin
            out_nd <= rd_acc;
            if (rd_acc) begin
                out_data0 <= mem[{rbank, rd_addr0}];
                out_data1 <= mem[{rbank, rd_addr1}];
            end
        end
    end
endmodule

// File: tb/tb_fft_stage_pingpong.sv
// Randomized and directed bench for fft_stage_pingpong, checked against a
// frame-queue model of the ping-pong buffer.
module tb_fft_stage_pingpong;
    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int WIDTH = 32;

    typedef logic [N*WIDTH-1:0] frame_t;
    typedef logic [N-1:0]       mask_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_nd = 1'b0, rd_en = 1'b0;
    logic [LOG_N-1:0] in_addr0 = '0, in_addr1 = '0, rd_addr0 = '0, rd_addr1 = '0;
    logic [WIDTH-1:0] in_data0 = '0, in_data1 = '0;
    logic             in_ready, rd_avail, out_nd, error;
    logic [WIDTH-1:0] out_data0, out_data1;

    fft_stage_pingpong #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_nd(in_nd), .in_addr0(in_addr0), .in_addr1(in_addr1),
        .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_avail(rd_avail), .out_nd(out_nd),
        .out_data0(out_data0), .out_data1(out_data1), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: frames in flight are a queue of completed frames plus the one being filled.
    frame_t     q_data[$];
    mask_t      q_mask[$];
    frame_t     wf_data;
    mask_t      wf_mask;
    int         wbeats, rbeats;
    bit         m_err;
    logic [WIDTH-1:0] e_d0, e_d1;
    bit         k0, k1;

    function automatic bit m_ready();
        return q_data.size() < 2;
    endfunction

    function automatic bit m_avail();
        return q_data.size() > 0;
    endfunction

    task automatic model_clear();
        q_data.delete(); q_mask.delete();
        wf_data = '0; wf_mask = '0;
        wbeats = 0; rbeats = 0; m_err = 0;
        e_d0 = '0; e_d1 = '0; k0 = 1; k1 = 1;
    endtask

    task automatic idle_inputs();
        in_nd = 0; rd_en = 0;
        in_addr0 = '0; in_addr1 = '0; in_data0 = '0; in_data1 = '0;
        rd_addr0 = '0; rd_addr1 = '0;
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic step(input bit nd, input int a0, input int a1, input int d0, input int d1,
                        input bit re, input int r0, input int r1);
        bit wr_ok, rd_ok, e_nd;
        frame_t fd;
        mask_t  fm;
        in_nd = nd; in_addr0 = a0[LOG_N-1:0]; in_addr1 = a1[LOG_N-1:0];
        in_data0 = WIDTH'(d0); in_data1 = WIDTH'(d1);
        rd_en = re; rd_addr0 = r0[LOG_N-1:0]; rd_addr1 = r1[LOG_N-1:0];
        #1;
        chk("in_ready", in_ready, m_ready());
        chk("rd_avail", rd_avail, m_avail());
        wr_ok = nd && m_ready();
        rd_ok = re && m_avail();
        if (nd && !wr_ok) m_err = 1;
        if (re && !rd_ok) m_err = 1;
        e_nd = rd_ok;
        if (rd_ok) begin
            fd = q_data[0]; fm = q_mask[0];
            k0 = fm[r0]; k1 = fm[r1];
            e_d0 = fd[r0*WIDTH +: WIDTH];
            e_d1 = fd[r1*WIDTH +: WIDTH];
            rbeats++;
            if (rbeats == N/2) begin
                rbeats = 0;
                void'(q_data.pop_front()); void'(q_mask.pop_front());
            end
        end
        if (wr_ok) begin
            wf_data[a0*WIDTH +: WIDTH] = WIDTH'(d0); wf_mask[a0] = 1'b1;
            wf_data[a1*WIDTH +: WIDTH] = WIDTH'(d1); wf_mask[a1] = 1'b1;
            if (a0 == a1) m_err = 1;
            wbeats++;
            if (wbeats == N/2) begin
                wbeats = 0;
                q_data.push_back(wf_data); q_mask.push_back(wf_mask);
                wf_mask = '0;
            end
        end
        @(posedge clk); #1;
        chk("out_nd", out_nd, e_nd);
        if (k0) chk("out_data0", out_data0, e_d0);
        if (k1) chk("out_data1", out_data1, e_d1);
        chk("error", error, m_err);
        @(negedge clk);
    endtask

    // Asserts rst between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        idle_inputs();
        #3; rst = 1; #1;
        chk("rst_out_nd", out_nd, 1'b0);
        chk("rst_out_data0", out_data0, '0);
        chk("rst_out_data1", out_data1, '0);
        chk("rst_error", error, 1'b0);
        chk("rst_rd_avail", rd_avail, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic write_frame(input int base);
        for (int b = 0; b < N/2; b++)
            step(1, b, b + N/2, base + b, base + b + N/2, 0, 0, 0);
    endtask

    task automatic read_frame();
        for (int b = 0; b < N/2; b++)
            step(0, 0, 0, 0, 0, 1, N - 1 - b, b);
    endtask

    task automatic scenario_basic();
        for (int b = 0; b < N/2; b++)
            step(1, b, b + 4, 10*b, 10*(b + 4), 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7, 0);
        chk("s1_data0_70", out_data0, 70);
        chk("s1_data1_0", out_data1, 0);
        step(0, 0, 0, 0, 0, 1, 3, 3);
        chk("s1_data_30", out_data0, 30);
        chk("s1_data_30b", out_data1, 30);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("s1_nd_drop", out_nd, 1'b0);
        chk("s1_hold", out_data0, 30);
    endtask

    int perm[N];
    task automatic shuffle();
        int j, t;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    task automatic random_phase(input bit legal, input int cycles);
        int wb = 0;
        bit nd, re, ok;
        int a0, a1;
        shuffle();
        for (int c = 0; c < cycles; c++) begin
            nd = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) != 0);
            if (legal && !m_ready()) nd = 0;
            if (legal && !m_avail()) re = 0;
            a0 = perm[2*wb]; a1 = perm[2*wb + 1];
            if (!legal && $urandom_range(0, 15) == 0) a1 = a0;
            ok = nd && m_ready();
            step(nd, a0, a1, int'($urandom), int'($urandom),
                 re, $urandom_range(0, N - 1), $urandom_range(0, N - 1));
            if (ok) begin
                wb++;
                if (wb == N/2) begin wb = 0; shuffle(); end
            end
        end
    endtask

    initial begin
        model_clear();
        idle_inputs();
        @(negedge clk);
        do_reset();

        scenario_basic();

        // Streaming: read A while B is written, then read B.
        write_frame(100);
        for (int b = 0; b < N/2; b++)
            step(1, b, b + N/2, 200 + b, 200 + b + N/2, 1, b + N/2, b);
        read_frame();

        // Overflow with two frames held.
        do_reset();
        write_frame(300);
        write_frame(400);
        step(1, 0, 1, 999, 998, 0, 0, 0);
        chk("ovf_error", error, 1'b1);
        read_frame();
        read_frame();

        // Underflow straight after reset.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("udf_error", error, 1'b1);

        // Collision: lane 1 wins.
        do_reset();
        step(1, 2, 2, 5, 9, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0);
        step(1, 3, 4, 3, 4, 0, 0, 0);
        step(1, 5, 6, 5, 6, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 2);
        chk("col_data", out_data0, 9);
        read_frame();

        // Simultaneous frame completion and release.
        do_reset();
        write_frame(500);
        for (int b = 0; b < N/2; b++)
            step(1, b, b + N/2, 600 + b, 600 + b + N/2, 1, b, b + N/2);
        chk("sim_avail", rd_avail, 1'b1);
        chk("sim_ready", in_ready, 1'b1);
        step(0, 0, 0, 0, 0, 1, 1, 6);
        chk("sim_new_frame", out_data0, 601);

        // Reset mid-operation, then the basic scenario again.
        do_reset();
        write_frame(700);
        step(1, 0, 1, 1, 2, 1, 0, 1);
        step(1, 2, 3, 3, 4, 0, 0, 0);
        do_reset();
        scenario_basic();

        do_reset();
        random_phase(1, 1500);
        chk("rand_legal_error", error, 1'b0);
        do_reset();
        random_phase(0, 800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
